// File: rtl/button_conditioner_pkg.sv
// Shared constants for the push-button front end: raw input indices,
// user_operation bit positions, arbiter state encodings and small helpers.
package button_conditioner_pkg;

  localparam int BTN_U = 0;
  localparam int BTN_L = 1;
  localparam int BTN_R = 2;
  localparam int BTN_D = 3;
  localparam int BTN_C = 4;
  localparam int IN_SW = 5;
  localparam int NUM_INPUTS = 6;

  localparam int OP_RESTART = 4;
  localparam int OP_UP      = 3;
  localparam int OP_LEFT    = 2;
  localparam int OP_DOWN    = 1;
  localparam int OP_RIGHT   = 0;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_FIRE = 2'd1;
  localparam arb_state_t ST_HOLD = 2'd2;
  localparam arb_state_t ST_GAP  = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One-hot pick of the highest-priority direction: U > L > D > R.
  function automatic logic [3:0] prio_pick(input logic [3:0] dirs);
    logic [3:0] pick;
    pick = '0;
    if (dirs[OP_UP])         pick[OP_UP]    = 1'b1;
    else if (dirs[OP_LEFT])  pick[OP_LEFT]  = 1'b1;
    else if (dirs[OP_DOWN])  pick[OP_DOWN]  = 1'b1;
    else if (dirs[OP_RIGHT]) pick[OP_RIGHT] = 1'b1;
    return pick;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_filter.sv
// Two-flop synchroniser followed by a stable-level counter; the level only
// flips after the synchronised input has differed for DEBOUNCE_CYCLES cycles.
module debounce_filter
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic level_next
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             differ;
  logic             expire;

  assign differ     = (sync_q != level);
  assign expire     = differ && (cnt_q == CNT_LAST);
  // Exported so the arbiter can register its pulse on the same edge the level flips.
  assign level_next = expire ? ~level : level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      level     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      level     <= level_next;
      if (!differ || expire)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces the five push-buttons and the restart switch, then issues
// single-cycle restart and move pulses, at most one move per physical press.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int GAP_CYCLES      = 2_000_000
) (
  input  logic       CLK_100M,
  input  logic       RST_N,
  input  logic [4:0] BTN,
  input  logic       SW_RESTART,
  output logic [4:0] user_operation,
  output logic [4:0] btn_level
);

  localparam int CW = $clog2(max_int(DEBOUNCE_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  logic [NUM_INPUTS-1:0] raw_in;
  logic [NUM_INPUTS-1:0] lvl;
  logic [NUM_INPUTS-1:0] lvl_next;

  assign raw_in = {SW_RESTART, BTN};

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_deb
    debounce_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk       (CLK_100M),
      .rst_n     (RST_N),
      .raw       (raw_in[i]),
      .level     (lvl[i]),
      .level_next(lvl_next[i])
    );
  end

  assign btn_level = {lvl[BTN_C], lvl[BTN_U], lvl[BTN_L], lvl[BTN_D], lvl[BTN_R]};

  logic [3:0] dir_next;
  logic       restart_q;
  logic       restart_d;
  logic       restart_rise;

  assign dir_next[OP_UP]    = lvl_next[BTN_U];
  assign dir_next[OP_LEFT]  = lvl_next[BTN_L];
  assign dir_next[OP_DOWN]  = lvl_next[BTN_D];
  assign dir_next[OP_RIGHT] = lvl_next[BTN_R];

  assign restart_q    = lvl[BTN_C] | lvl[IN_SW];
  assign restart_d    = lvl_next[BTN_C] | lvl_next[IN_SW];
  assign restart_rise = restart_d & ~restart_q;

  arb_state_t    state_q;
  arb_state_t    state_d;
  logic [CW-1:0] gap_q;
  logic [CW-1:0] gap_d;
  logic [3:0]    move_d;

  // The arbiter looks at next-cycle debounced levels so that a move pulse is
  // registered on the very edge its debounced level goes high.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    move_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|dir_next) begin
          state_d = ST_FIRE;
          move_d  = prio_pick(dir_next);
        end
      end
      ST_FIRE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (!(|dir_next)) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (|dir_next)
          state_d = ST_HOLD;
        else if (gap_q == GAP_LAST)
          state_d = ST_IDLE;
        else
          gap_d = gap_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (restart_rise && (move_d != 4'b0)) begin
      move_d  = '0;
      state_d = ST_HOLD;
    end
  end

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= ST_IDLE;
      gap_q          <= '0;
      user_operation <= '0;
    end else begin
      state_q        <= state_d;
      gap_q          <= gap_d;
      user_operation <= {restart_rise, move_d};
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: table of press/release steps plus hand-written
// bounce, gap and reset sequences; pulses are checked against a scoreboard.
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn;
  logic       sw;
  logic [4:0] user_operation;
  logic [4:0] btn_level;

  button_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .GAP_CYCLES     (16)
  ) dut (
    .CLK_100M      (clk),
    .RST_N         (rst_n),
    .BTN           (btn),
    .SW_RESTART    (sw),
    .user_operation(user_operation),
    .btn_level     (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [4:0] op;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [4:0] btn;
    logic       sw;
    int         hold;
    logic [4:0] exp_op;
    logic [4:0] exp_lvl;
  } vec_t;

  vec_t vecs[9];

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] prev_op = '0;

  task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Raw inputs change half a cycle after a posedge; a resulting pulse lands 10 cycles later.
  task automatic applyStimulus(input logic [4:0] b, input logic s, input logic [4:0] exp_op);
    exp_t e;
    btn = b;
    sw  = s;
    if (exp_op != 5'b0) begin
      e.at = cyc + 10;
      e.op = exp_op;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0 && exp_q[0].at == cyc) begin
      checkOutput("pulse", user_operation, exp_q[0].op);
      void'(exp_q.pop_front());
    end else if (user_operation != 5'b0) begin
      checkOutput("unexpected_pulse", user_operation, 5'b0);
    end
    if ((user_operation & prev_op) != 5'b0)
      checkOutput("back_to_back", user_operation & prev_op, 5'b0);
    if ($countones(user_operation[3:0]) > 1)
      checkOutput("move_onehot", user_operation, 5'b0);
    prev_op = user_operation;
  end

  initial begin
    logic [4:0] lvl_seen;
    exp_t       e;

    vecs[0] = '{5'b00001, 1'b0, 100, 5'b01000, 5'b01000};
    vecs[1] = '{5'b00000, 1'b0,  40, 5'b00000, 5'b00000};
    vecs[2] = '{5'b00110, 1'b0,  40, 5'b00100, 5'b00101};
    vecs[3] = '{5'b00100, 1'b0,  30, 5'b00000, 5'b00001};
    vecs[4] = '{5'b00000, 1'b0,  40, 5'b00000, 5'b00000};
    vecs[5] = '{5'b11000, 1'b0,  30, 5'b10000, 5'b10010};
    vecs[6] = '{5'b00000, 1'b0,  40, 5'b00000, 5'b00000};
    vecs[7] = '{5'b00000, 1'b1,  30, 5'b10000, 5'b00000};
    vecs[8] = '{5'b00000, 1'b0,  30, 5'b00000, 5'b00000};

    rst_n = 1'b0;
    btn   = '0;
    sw    = 1'b0;
    wait_cycles(3);
    checkOutput("reset_op", user_operation, 5'b0);
    checkOutput("reset_lvl", btn_level, 5'b0);
    rst_n = 1'b1;
    wait_cycles(5);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].btn, vecs[i].sw, vecs[i].exp_op);
      wait_cycles(vecs[i].hold);
      checkOutput($sformatf("table_lvl_%0d", i), btn_level, vecs[i].exp_lvl);
    end

    // Bounce on R: never stable long enough to flip the level.
    lvl_seen = '0;
    for (int i = 0; i < 20; i++) begin
      btn[2] = ~btn[2];
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        lvl_seen = lvl_seen | btn_level;
      end
    end
    btn = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lvl_seen = lvl_seen | btn_level;
    end
    checkOutput("bounce_lvl", lvl_seen, 5'b0);

    // R pressed inside the gap after U is swallowed; pressed after the gap it fires.
    applyStimulus(5'b00001, 1'b0, 5'b01000);
    wait_cycles(30);
    applyStimulus(5'b00000, 1'b0, 5'b0);
    wait_cycles(10);
    checkOutput("gap_u_released", btn_level, 5'b0);
    wait_cycles(5);
    applyStimulus(5'b00100, 1'b0, 5'b0);
    wait_cycles(30);
    checkOutput("gap_r_held", btn_level, 5'b00001);
    applyStimulus(5'b00000, 1'b0, 5'b0);
    wait_cycles(40);
    applyStimulus(5'b00100, 1'b0, 5'b00001);
    wait_cycles(30);
    applyStimulus(5'b00000, 1'b0, 5'b0);
    wait_cycles(40);

    // Reset with a debounced level high clears it at once; held R refires.
    applyStimulus(5'b00100, 1'b0, 5'b00001);
    wait_cycles(20);
    checkOutput("pre_reset_lvl", btn_level, 5'b00001);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_lvl", btn_level, 5'b0);
    wait_cycles(3);
    rst_n = 1'b1;
    e.at = cyc + 10;
    e.op = 5'b00001;
    exp_q.push_back(e);
    wait_cycles(20);
    applyStimulus(5'b00000, 1'b0, 5'b0);
    wait_cycles(40);

    // Reset mid-gap with U raised again; U fires once after release.
    applyStimulus(5'b00001, 1'b0, 5'b01000);
    wait_cycles(30);
    applyStimulus(5'b00000, 1'b0, 5'b0);
    wait_cycles(12);
    applyStimulus(5'b00001, 1'b0, 5'b0);
    wait_cycles(5);
    rst_n = 1'b0;
    #1;
    checkOutput("gap_reset_op", user_operation, 5'b0);
    checkOutput("gap_reset_lvl", btn_level, 5'b0);
    wait_cycles(3);
    rst_n = 1'b1;
    e.at = cyc + 10;
    e.op = 5'b01000;
    exp_q.push_back(e);
    wait_cycles(30);
    checkOutput("post_reset_u_lvl", btn_level, 5'b01000);
    applyStimulus(5'b00000, 1'b0, 5'b0);
    wait_cycles(40);

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("[TB] FAIL missing_pulses: %0d outstanding, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
